// File: rtl/sips4_pkg.sv
// Shared types and widths for the SIPS4 data-RAM arbiter.
package sips4_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned ADDR_W = 4;

   typedef logic port_id_t;

   typedef enum logic {
      RR   = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W-1:0]     wdata;
      port_id_t              id;
   } ram_cmd_t;

endpackage

// File: rtl/sips4_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request ports and their read responses.
interface sips4_ram_arbiter_if;
   import sips4_pkg::*;

   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_lock;
   logic              req1_ready;
   logic              rsp0_valid;
   logic [DATA_W-1:0] rsp0_rdata;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp1_rdata;

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
   );

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
   );

endinterface

// File: rtl/sips4_rr_pick2.sv
// Combinational two-way winner select: lock-only, starvation override, then round-robin.
module sips4_rr_pick2
   import sips4_pkg::*;
(
   input  logic [1:0] valid_i,
   input  port_id_t   last_i,
   input  logic       force0_i,
   input  logic       lock_only_i,
   output logic       gnt_valid_c_o,
   output port_id_t   gnt_id_c_o
);

   always_comb begin
      gnt_valid_c_o = 1'b0;
      gnt_id_c_o    = 1'b0;
      if (lock_only_i) begin
         gnt_valid_c_o = valid_i[1];
         gnt_id_c_o    = 1'b1;
      end else if (valid_i == 2'b11) begin
         gnt_valid_c_o = 1'b1;
         gnt_id_c_o    = force0_i ? 1'b0 : ~last_i;
      end else if (valid_i[0]) begin
         gnt_valid_c_o = 1'b1;
         gnt_id_c_o    = 1'b0;
      end else if (valid_i[1]) begin
         gnt_valid_c_o = 1'b1;
         gnt_id_c_o    = 1'b1;
      end
   end

endmodule

// File: rtl/sips4_ram_arbiter.sv
// Shares the SIPS4 data RAM between the CPU port (0) and the loader port (1),
// one access per cycle, with a bounded exclusive-lock mode for loader bursts.
module sips4_ram_arbiter
   import sips4_pkg::*;
#(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sips4_ram_arbiter_if.slave bus,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   arb_state_t       state_q, state_d;
   port_id_t         last_q, last_d;
   logic             starve0_q, starve0_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
   ram_cmd_t         cmd_q, cmd_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic             gnt_valid, gnt1;
   port_id_t         gnt_id;

   // Requests are masked during reset so ready stays low while rst_n is asserted.
   sips4_rr_pick2 u_pick (
      .valid_i       ({bus.req1_valid & rst_n, bus.req0_valid & rst_n}),
      .last_i        (last_q),
      .force0_i      ((state_q == RR) && starve0_q),
      .lock_only_i   ((state_q == LOCK) && bus.req1_lock),
      .gnt_valid_c_o (gnt_valid),
      .gnt_id_c_o    (gnt_id)
   );

   assign gnt1           = gnt_valid && (gnt_id == 1'b1);
   assign bus.req0_ready = gnt_valid && (gnt_id == 1'b0);
   assign bus.req1_ready = gnt1;
   assign lock_cnt_inc   = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      starve0_d   = starve0_q;
      lock_cnt_d  = lock_cnt_q;
      cmd_d       = cmd_q;
      cmd_valid_d = gnt_valid;
      rsp_valid_d = 2'b00;
      if (cmd_valid_q && !cmd_q.we) rsp_valid_d[cmd_q.id] = 1'b1;
      if (gnt_valid) begin
         last_d = gnt_id;
         if (gnt_id == 1'b0) begin
            cmd_d     = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata, id: 1'b0};
            starve0_d = 1'b0;
         end else begin
            cmd_d = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata, id: 1'b1};
         end
      end
      case (state_q)
         RR: begin
            if (gnt1 && bus.req1_lock) begin
               lock_cnt_d = CNT_W'(1);
               if (LOCK_MAX == 1) starve0_d = 1'b1;
               else               state_d   = LOCK;
            end
         end
         LOCK: begin
            if (!bus.req1_lock) begin
               state_d = RR;
            end else if (gnt1) begin
               lock_cnt_d = lock_cnt_inc;
               // Burst budget spent: hand the next RR slot to port 0.
               if (lock_cnt_inc == CNT_MAX) begin
                  state_d   = RR;
                  starve0_d = 1'b1;
               end
            end
         end
         default: state_d = RR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RR;
         last_q      <= 1'b1;
         starve0_q   <= 1'b0;
         lock_cnt_q  <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         rsp_valid_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         starve0_q   <= starve0_d;
         lock_cnt_q  <= lock_cnt_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign ram_wen        = cmd_valid_q && cmd_q.we;
   assign ram_waddr      = cmd_q.addr;
   assign ram_raddr      = cmd_q.addr;
   assign ram_wdata      = cmd_q.wdata;
   assign bus.rsp0_valid = rsp_valid_q[0];
   assign bus.rsp1_valid = rsp_valid_q[1];
   assign bus.rsp0_rdata = rsp_valid_q[0] ? ram_rdata : '0;
   assign bus.rsp1_rdata = rsp_valid_q[1] ? ram_rdata : '0;

endmodule

// File: tb/tb_sips4_ram_arbiter.sv
// Scoreboard bench for sips4_ram_arbiter: scripted requesters, behavioural RAM, shadow memory.
module tb_sips4_ram_arbiter;
   import sips4_pkg::*;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [3:0] wdata;
      logic       lock;
   } req_t;

   typedef struct {
      int         id;
      logic [3:0] data;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   sips4_ram_arbiter_if bus ();

   logic       ram_wen;
   logic [3:0] ram_waddr, ram_raddr, ram_wdata;
   logic [3:0] ram_rdata = '0;
   logic [3:0] mem [16] = '{default: '0};

   sips4_ram_arbiter #(.LOCK_MAX(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_wen   (ram_wen),
      .ram_waddr (ram_waddr),
      .ram_raddr (ram_raddr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Synchronous-read RAM: q is valid one cycle after the address is sampled.
   always @(posedge clk) begin
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   req_t       p0q[$], p1q[$];
   exp_t       sb[$];
   int         gseq[$], expg[$];
   logic [3:0] shadow [16] = '{default: '0};
   int         n_cmp = 0, n_err = 0, cyc = 0;
   logic       prev_v = 1'b0, prev_we = 1'b0;
   logic [3:0] prev_addr = '0, prev_wdata = '0;

   function automatic req_t mk(logic we, int addr, int wd, logic lock);
      req_t r;
      r.we = we; r.addr = 4'(addr); r.wdata = 4'(wd); r.lock = lock;
      return r;
   endfunction

   function automatic void add(int v, int n);
      for (int i = 0; i < n; i++) expg.push_back(v);
   endfunction

   task automatic drive_inputs();
      bus.req0_valid = (p0q.size() > 0);
      bus.req0_we    = (p0q.size() > 0) ? p0q[0].we    : 1'b0;
      bus.req0_addr  = (p0q.size() > 0) ? p0q[0].addr  : 4'h0;
      bus.req0_wdata = (p0q.size() > 0) ? p0q[0].wdata : 4'h0;
      bus.req1_valid = (p1q.size() > 0);
      bus.req1_we    = (p1q.size() > 0) ? p1q[0].we    : 1'b0;
      bus.req1_addr  = (p1q.size() > 0) ? p1q[0].addr  : 4'h0;
      bus.req1_wdata = (p1q.size() > 0) ? p1q[0].wdata : 4'h0;
      bus.req1_lock  = (p1q.size() > 0) ? p1q[0].lock  : 1'b0;
   endtask

   // One clock: scoreboard the response and RAM port, record the grant, advance.
   task automatic cycle(output int g);
      exp_t       e;
      logic       w0, w1, exp_wen;
      logic [3:0] wd;
      req_t       r;
      @(negedge clk);
      w0 = 1'b0; w1 = 1'b0; wd = 4'h0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e  = sb.pop_front();
         w0 = (e.id == 0); w1 = (e.id == 1); wd = e.data;
      end
      n_cmp++;
      if (bus.rsp0_valid !== w0 || bus.rsp1_valid !== w1 ||
          bus.rsp0_rdata !== (w0 ? wd : 4'h0) || bus.rsp1_rdata !== (w1 ? wd : 4'h0)) begin
         n_err++;
         $display("FAIL rsp cyc=%0d got v0=%b d0=%h v1=%b d1=%h want v0=%b v1=%b d=%h",
                  cyc, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata, w0, w1, wd);
      end
      exp_wen = prev_v && prev_we && rst_n;
      n_cmp++;
      if (ram_wen !== exp_wen || (prev_v && rst_n && (ram_waddr !== prev_addr ||
          ram_raddr !== prev_addr || (prev_we && ram_wdata !== prev_wdata)))) begin
         n_err++;
         $display("FAIL ram_port cyc=%0d got wen=%b wa=%h ra=%h wd=%h want wen=%b a=%h wd=%h",
                  cyc, ram_wen, ram_waddr, ram_raddr, ram_wdata, exp_wen, prev_addr, prev_wdata);
      end
      n_cmp++;
      if ($isunknown({bus.req0_ready, bus.req1_ready}) || (bus.req0_ready && bus.req1_ready) ||
          (bus.req0_ready && !bus.req0_valid) || (bus.req1_ready && !bus.req1_valid)) begin
         n_err++;
         $display("FAIL ready cyc=%0d got r0=%b r1=%b v0=%b v1=%b want one-hot-or-zero gated by valid",
                  cyc, bus.req0_ready, bus.req1_ready, bus.req0_valid, bus.req1_valid);
      end
      g = bus.req0_ready === 1'b1 ? 0 : (bus.req1_ready === 1'b1 ? 1 : -1);
      prev_v = 1'b0;
      if ((g == 0 && p0q.size() > 0) || (g == 1 && p1q.size() > 0)) begin
         r = (g == 0) ? p0q.pop_front() : p1q.pop_front();
         if (r.we) shadow[r.addr] = r.wdata;
         else      sb.push_back('{id: g, data: shadow[r.addr], due: cyc + 2});
         prev_v = 1'b1; prev_we = r.we; prev_addr = r.addr; prev_wdata = r.wdata;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_inputs();
   endtask

   task automatic drive_ports(int ncyc);
      int g;
      gseq.delete();
      for (int i = 0; i < ncyc; i++) begin
         cycle(g);
         gseq.push_back(g);
      end
   endtask

   task automatic do_reset();
      int g;
      rst_n = 1'b0;
      sb.delete();
      prev_v = 1'b0;
      cycle(g);
      cycle(g);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 4'h3; bus.req0_wdata = 4'h0;
      bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 4'h4; bus.req1_wdata = 4'hF;
      bus.req1_lock  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.req0_ready, bus.req1_ready, ram_wen, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0 ||
             {ram_waddr, ram_raddr, ram_wdata, bus.rsp0_rdata, bus.rsp1_rdata} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_values got rdy=%b%b wen=%b rv=%b%b wa=%h ra=%h wd=%h rd=%h/%h want all zero",
                     bus.req0_ready, bus.req1_ready, ram_wen, bus.rsp0_valid, bus.rsp1_valid,
                     ram_waddr, ram_raddr, ram_wdata, bus.rsp0_rdata, bus.rsp1_rdata);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_inputs();
   endtask

   task automatic test_write_read();
      p0q.push_back(mk(1'b1, 3, 'hA, 1'b0));
      p0q.push_back(mk(1'b0, 3, 0, 1'b0));
      drive_inputs();
      drive_ports(6);
      expg.delete(); add(0, 2); add(-1, 4);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL write_read grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   task automatic test_alternate();
      p0q.push_back(mk(1'b1, 1, 'h5, 1'b0));
      p1q.push_back(mk(1'b1, 2, 'hC, 1'b0));
      for (int i = 0; i < 4; i++) begin
         p0q.push_back(mk(1'b0, 1, 0, 1'b0));
         p1q.push_back(mk(1'b0, 2, 0, 1'b0));
      end
      drive_inputs();
      drive_ports(13);
      expg.delete();
      for (int i = 0; i < 5; i++) begin add(1, 1); add(0, 1); end
      add(-1, 3);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL alternate grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   task automatic test_tie_after_reset();
      do_reset();
      p1q.push_back(mk(1'b1, 5, 'h7, 1'b0));
      p0q.push_back(mk(1'b0, 5, 0, 1'b0));
      p0q.push_back(mk(1'b0, 5, 0, 1'b0));
      drive_inputs();
      drive_ports(6);
      expg.delete(); add(0, 1); add(1, 1); add(0, 1); add(-1, 3);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL tie_after_reset grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   task automatic test_lock_max();
      for (int i = 0; i < 12; i++) p1q.push_back(mk(1'b0, 6, 0, 1'b1));
      for (int i = 0; i < 3; i++)  p0q.push_back(mk(1'b0, 3, 0, 1'b0));
      drive_inputs();
      drive_ports(18);
      expg.delete(); add(1, 8); add(0, 1); add(1, 4); add(0, 2); add(-1, 3);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL lock_max grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   task automatic test_lock_drop();
      p1q.push_back(mk(1'b1, 7, 'h9, 1'b1));
      p1q.push_back(mk(1'b0, 7, 0, 1'b1));
      p1q.push_back(mk(1'b0, 7, 0, 1'b1));
      p1q.push_back(mk(1'b0, 7, 0, 1'b0));
      p1q.push_back(mk(1'b0, 7, 0, 1'b0));
      for (int i = 0; i < 3; i++) p0q.push_back(mk(1'b0, 3, 0, 1'b0));
      drive_inputs();
      drive_ports(11);
      expg.delete(); add(1, 3); add(0, 1); add(1, 1); add(0, 1); add(1, 1); add(0, 1); add(-1, 3);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL lock_drop grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int g;
      p0q.push_back(mk(1'b0, 3, 0, 1'b0));
      drive_inputs();
      cycle(g);
      n_cmp++;
      if (g !== 0) begin
         n_err++;
         $display("FAIL reset_mid_accept got grant %0d want 0", g);
      end
      rst_n = 1'b0;
      sb.delete();
      prev_v = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.req0_ready, bus.req1_ready, ram_wen, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0 ||
             {ram_waddr, ram_raddr, ram_wdata, bus.rsp0_rdata, bus.rsp1_rdata} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_mid_values got rdy=%b%b wen=%b rv=%b%b wa=%h ra=%h want all zero",
                     bus.req0_ready, bus.req1_ready, ram_wen, bus.rsp0_valid, bus.rsp1_valid,
                     ram_waddr, ram_raddr);
         end
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      p0q.push_back(mk(1'b0, 1, 0, 1'b0));
      p1q.push_back(mk(1'b0, 2, 0, 1'b0));
      drive_inputs();
      drive_ports(6);
      expg.delete(); add(0, 1); add(1, 1); add(-1, 4);
      for (int i = 0; i < expg.size(); i++) begin
         n_cmp++;
         if (gseq[i] !== expg[i]) begin
            n_err++;
            $display("FAIL reset_mid_tie grant[%0d] got %0d want %0d", i, gseq[i], expg[i]);
         end
      end
   endtask

   initial begin
      drive_inputs();
      test_reset();
      test_write_read();
      test_alternate();
      test_tie_after_reset();
      test_lock_max();
      test_lock_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
